enc_dec_apb_regbank: RTL and testbench

- APB slave register bank sitting directly upstream of the encoder/decoder core.
- Holds the four CPU-visible registers: CTRL, DATA_IN, CODEWORD_WIDTH, NOISE.
- A write to CTRL launches one core operation via a start pulse.
- Stalls further APB writes with PREADY until the core reports operation_done, so register contents are stable for the whole operation.

---
 rtl/enc_dec_apb_regbank_if.sv | 24 ++
 rtl/enc_dec_apb_regbank.sv | 156 +++++++++++++++
 tb/tb_enc_dec_apb_regbank.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/enc_dec_apb_regbank_if.sv
// APB3 bus bundle between the CPU bridge and the encoder/decoder register bank.
// Ports: PADDR/PSEL/PENABLE/PWRITE/PWDATA from master, PRDATA/PREADY from slave.
interface enc_dec_apb_regbank_if #(
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int AMBA_WORD       = 32
);
    logic [AMBA_ADDR_WIDTH-1:0] PADDR;
    logic                       PSEL;
    logic                       PENABLE;
    logic                       PWRITE;
    logic [AMBA_WORD-1:0]       PWDATA;
    logic [AMBA_WORD-1:0]       PRDATA;
    logic                       PREADY;

    modport master (
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        input  PRDATA, PREADY
    );

    modport slave (
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        output PRDATA, PREADY
    );
endinterface

// File: rtl/enc_dec_apb_regbank.sv
// APB register bank (CTRL, DATA_IN, CODEWORD_WIDTH, NOISE) feeding the
// encoder/decoder core; a CTRL write launches an operation via start.
// Ports: clk, rst (async active-low), s_apb (APB slave bundle),
//        ctrl/data_in/codeword_width/noise (register contents to the core),
//        start (launch pulse), busy (operation in flight),
//        operation_done (core completion pulse).
module enc_dec_apb_regbank #(
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int AMBA_WORD       = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    enc_dec_apb_regbank_if.slave s_apb,
    output logic [1:0]           ctrl,
    output logic [AMBA_WORD-1:0] data_in,
    output logic [1:0]           codeword_width,
    output logic [AMBA_WORD-1:0] noise,
    output logic                 start,
    output logic                 busy,
    input  logic                 operation_done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2
    } state_t;

    localparam logic [1:0] A_CTRL  = 2'b00;
    localparam logic [1:0] A_DATA  = 2'b01;
    localparam logic [1:0] A_CWW   = 2'b10;
    localparam logic [1:0] A_NOISE = 2'b11;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [AMBA_WORD-1:0] r_ctrl;
    logic [AMBA_WORD-1:0] r_data_in;
    logic [AMBA_WORD-1:0] r_cww;
    logic [AMBA_WORD-1:0] r_noise;
    logic [AMBA_WORD-1:0] r_prdata;
    logic [AMBA_WORD-1:0] w_rd_mux;

    logic [1:0]           w_addr;
    logic                 w_pready;
    logic                 w_wr_commit;
    logic                 w_rd_sel;
    logic                 w_launch;
    logic                 w_unused_addr;

    assign w_addr = s_apb.PADDR[3:2];

    // Only [3:2] select a register; remaining address bits are don't-care.
    assign w_unused_addr = ^{s_apb.PADDR[AMBA_ADDR_WIDTH-1:4],
                             s_apb.PADDR[1:0]};

    // Writes are held off while an operation runs so the core sees
    // stable register contents; reads are always zero-wait.
    assign w_pready = ~(s_apb.PSEL & s_apb.PWRITE & (r_state != ST_IDLE));

    assign w_wr_commit = s_apb.PSEL & s_apb.PENABLE
                       & s_apb.PWRITE & w_pready;

    // Load read data in both setup and access phases so the registered
    // PRDATA is already valid when the access phase begins.
    assign w_rd_sel = s_apb.PSEL & ~s_apb.PWRITE;

    // CTRL op code 2'b11 is reserved: stored, but never launches.
    assign w_launch = w_wr_commit & (w_addr == A_CTRL)
                    & (s_apb.PWDATA[1:0] != 2'b11);

    always_comb begin
        w_rd_mux = '0;
        unique case (w_addr)
            A_CTRL:  w_rd_mux = r_ctrl;
            A_DATA:  w_rd_mux = r_data_in;
            A_CWW:   w_rd_mux = r_cww;
            A_NOISE: w_rd_mux = r_noise;
            default: w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ctrl    <= '0;
            r_data_in <= '0;
            r_cww     <= '0;
            r_noise   <= '0;
        end else if (w_wr_commit) begin
            unique case (w_addr)
                A_CTRL:  r_ctrl    <= s_apb.PWDATA;
                A_DATA:  r_data_in <= s_apb.PWDATA;
                A_CWW:   r_cww     <= s_apb.PWDATA;
                A_NOISE: r_noise   <= s_apb.PWDATA;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prdata <= '0;
        end else if (w_rd_sel) begin
            r_prdata <= w_rd_mux;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        start       = 1'b0;
        busy        = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_launch) begin
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                start = 1'b1;
                busy  = 1'b1;
                // A completion arriving already in the launch cycle
                // must not be lost.
                if (operation_done) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                busy = 1'b1;
                if (operation_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign s_apb.PREADY   = w_pready;
    assign s_apb.PRDATA   = r_prdata;
    assign ctrl           = r_ctrl[1:0];
    assign data_in        = r_data_in;
    assign codeword_width = r_cww[1:0];
    assign noise          = r_noise;

endmodule

// File: tb/tb_enc_dec_apb_regbank.sv
// Self-checking bench for enc_dec_apb_regbank with a register/busy model.
// Drives APB through the interface and plays the core's operation_done.
module tb_enc_dec_apb_regbank;

    localparam int AW = 20;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    ctrl;
    logic [DW-1:0] data_in;
    logic [1:0]    codeword_width;
    logic [DW-1:0] noise;
    logic          start;
    logic          busy;
    logic          operation_done;

    always #5 clk = ~clk;

    enc_dec_apb_regbank_if #(
        .AMBA_ADDR_WIDTH(AW),
        .AMBA_WORD(DW)
    ) apb ();

    enc_dec_apb_regbank #(
        .AMBA_ADDR_WIDTH(AW),
        .AMBA_WORD(DW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .s_apb          (apb),
        .ctrl           (ctrl),
        .data_in        (data_in),
        .codeword_width (codeword_width),
        .noise          (noise),
        .start          (start),
        .busy           (busy),
        .operation_done (operation_done)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [DW-1:0] m_reg [4];

    task automatic check(input string tag,
                         input logic [DW-1:0] obs,
                         input logic [DW-1:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] mk_addr(input int idx);
        logic [AW-1:0] a;
        logic [1:0]    i2;
        a     = AW'($urandom);
        i2    = idx[1:0];
        a[3:2] = i2;
        return a;
    endfunction

    task automatic apb_write(input int idx, input logic [DW-1:0] d,
                             output int waits);
        bit ok;
        ok = 1'b1;
        @(posedge clk); #1;
        apb.PADDR   = mk_addr(idx);
        apb.PWDATA  = d;
        apb.PWRITE  = 1'b1;
        apb.PSEL    = 1'b1;
        apb.PENABLE = 1'b0;
        @(posedge clk); #1;
        apb.PENABLE = 1'b1;
        waits = 0;
        while (1) begin
            @(negedge clk);
            if (apb.PREADY) break;
            waits++;
            if (waits > 300) begin
                check("wr_timeout", 32'd1, 32'd0);
                ok = 1'b0;
                break;
            end
        end
        @(posedge clk); #1;
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = 1'b0;
        if (ok) m_reg[idx] = d;
    endtask

    task automatic apb_read(input int idx, output logic [DW-1:0] d);
        @(posedge clk); #1;
        apb.PADDR   = mk_addr(idx);
        apb.PWRITE  = 1'b0;
        apb.PSEL    = 1'b1;
        apb.PENABLE = 1'b0;
        @(posedge clk); #1;
        apb.PENABLE = 1'b1;
        @(negedge clk);
        check("rd_pready", 32'(apb.PREADY), 32'd1);
        d = apb.PRDATA;
        @(posedge clk); #1;
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
    endtask

    task automatic read_check(input int idx, input string tag);
        logic [DW-1:0] d;
        apb_read(idx, d);
        check(tag, d, m_reg[idx]);
    endtask

    task automatic check_outs(input string tag);
        check({tag, "_ctrl"}, 32'(ctrl), 32'(m_reg[0][1:0]));
        check({tag, "_din"}, data_in, m_reg[1]);
        check({tag, "_cww"}, 32'(codeword_width), 32'(m_reg[2][1:0]));
        check({tag, "_noise"}, noise, m_reg[3]);
    endtask

    task automatic pulse_done();
        @(posedge clk); #1;
        operation_done = 1'b1;
        @(posedge clk); #1;
        operation_done = 1'b0;
    endtask

    // Launch an operation; start must appear in the cycle after commit.
    task automatic launch(input logic [1:0] op, input string tag);
        int w;
        logic [DW-1:0] d;
        d      = $urandom;
        d[1:0] = op;
        apb_write(0, d, w);
        check({tag, "_wait"}, 32'(w), 32'd0);
        @(negedge clk);
        check({tag, "_start"}, 32'(start), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        @(negedge clk);
        check({tag, "_start_off"}, 32'(start), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w;
        int seen;
        logic [DW-1:0] d;

        rst            = 1'b0;
        operation_done = 1'b0;
        apb.PSEL       = 1'b0;
        apb.PENABLE    = 1'b0;
        apb.PWRITE     = 1'b0;
        apb.PADDR      = '0;
        apb.PWDATA     = '0;
        for (int i = 0; i < 4; i++) m_reg[i] = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pready", 32'(apb.PREADY), 32'd1);
        check("rst_start", 32'(start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_prdata", apb.PRDATA, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        for (int i = 0; i < 4; i++) read_check(i, "rst_rd");
        check_outs("rst");

        // Basic launch with known operands.
        apb_write(1, 32'h0000_00A5, w);
        check("wr_wait_idle", 32'(w), 32'd0);
        apb_write(2, 32'h0, w);
        apb_write(3, 32'h1, w);
        launch(2'b00, "enc");
        check_outs("enc");

        // Read while busy: zero wait, current contents, stays busy.
        read_check(1, "rd_busy");
        check("rd_busy_stay", 32'(busy), 32'd1);

        // Stalled write during a long operation.
        fork
            apb_write(1, 32'h1234_5678, w);
            begin
                repeat (2) @(posedge clk);
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    check("stall_pready", 32'(apb.PREADY), 32'd0);
                    check("stall_din", data_in, 32'h0000_00A5);
                    check("stall_busy", 32'(busy), 32'd1);
                end
                pulse_done();
                @(negedge clk);
                check("done_pready", 32'(apb.PREADY), 32'd1);
                check("done_busy", 32'(busy), 32'd0);
            end
        join
        check("stall_waits", 32'(w), 32'd11);
        check("stall_commit", data_in, 32'h1234_5678);
        check_outs("stall");

        // Reserved op code: stored, no launch.
        d      = $urandom;
        d[1:0] = 2'b11;
        seen   = 0;
        fork
            apb_write(0, d, w);
            repeat (8) begin
                @(negedge clk);
                if (start) seen++;
            end
        join
        check("op11_nostart", 32'(seen), 32'd0);
        check("op11_busy", 32'(busy), 32'd0);
        read_check(0, "op11_rd");

        // Completion while idle is ignored.
        pulse_done();
        @(negedge clk);
        check("idle_done_busy", 32'(busy), 32'd0);
        check("idle_done_start", 32'(start), 32'd0);

        // Completion in the launch cycle.
        apb_write(0, 32'h2, w);
        operation_done = 1'b1;
        @(negedge clk);
        check("st_done_start", 32'(start), 32'd1);
        @(posedge clk); #1;
        operation_done = 1'b0;
        @(negedge clk);
        check("st_done_busy", 32'(busy), 32'd0);
        check("st_done_start0", 32'(start), 32'd0);

        // Back-to-back: stalled CTRL write launches in first idle cycle.
        launch(2'b10, "b2b0");
        fork
            apb_write(0, 32'h1, w);
            begin
                repeat (5) @(posedge clk);
                pulse_done();
            end
        join
        @(negedge clk);
        check("b2b_start", 32'(start), 32'd1);
        check("b2b_ctrl", 32'(ctrl), 32'd1);
        pulse_done();
        @(negedge clk);
        check("b2b_idle", 32'(busy), 32'd0);

        // Randomized traffic against the model.
        for (int it = 0; it < 40; it++) begin
            int r;
            r = $urandom_range(0, 3);
            if (it % 8 == 7) begin
                launch(2'($urandom_range(0, 2)), "rnd_launch");
                check_outs("rnd_launch");
                repeat ($urandom_range(0, 4)) @(posedge clk);
                read_check($urandom_range(0, 3), "rnd_rd_busy");
                pulse_done();
                @(negedge clk);
                check("rnd_idle", 32'(busy), 32'd0);
            end else if (r == 0) begin
                read_check($urandom_range(0, 3), "rnd_rd");
            end else begin
                apb_write(r, $urandom, w);
                check("rnd_wr_wait", 32'(w), 32'd0);
                read_check(r, "rnd_wr_rd");
            end
        end
        check_outs("rnd_end");

        // Reset in the middle of an operation.
        launch(2'b01, "pre_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_start", 32'(start), 32'd0);
        check("mid_rst_pready", 32'(apb.PREADY), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) m_reg[i] = '0;
        for (int i = 0; i < 4; i++) read_check(i, "mid_rst_rd");
        check_outs("mid_rst");
        launch(2'b01, "post_rst");
        check("post_rst_ctrl", 32'(ctrl), 32'd1);
        pulse_done();
        @(negedge clk);
        check("post_rst_idle", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
